// File: rtl/icosoc_mod_mpwm_pkg.sv
// Register map and bit positions shared by the mpwm top level and its channel slices.
package icosoc_mod_mpwm_pkg;

  localparam logic [15:0] ADDR_CTRL     = 16'h0000;
  localparam logic [15:0] ADDR_PERIOD   = 16'h0004;
  localparam logic [15:0] ADDR_PRESCALE = 16'h0008;
  localparam logic [15:0] ADDR_COUNT    = 16'h000C;
  localparam logic [15:0] ADDR_STATUS   = 16'h0010;

  localparam logic [15:0] CH_BASE   = 16'h0100;
  localparam logic [15:0] CH_STRIDE = 16'h0010;
  localparam logic [3:0]  CH_ON     = 4'h0;
  localparam logic [3:0]  CH_OFF    = 4'h4;
  localparam logic [3:0]  CH_CFG    = 4'h8;

  localparam int unsigned CTRL_RUN    = 0;
  localparam int unsigned CTRL_COMMIT = 1;
  localparam int unsigned STAT_PEND   = 0;
  localparam int unsigned STAT_WRAP   = 1;
  localparam int unsigned CFG_EN      = 0;
  localparam int unsigned CFG_POL     = 1;

endpackage

// File: rtl/icosoc_mod_mpwm_chan.sv
// One PWM channel: ON/OFF/CFG shadow and active copies, compare logic and the output pin register.
module icosoc_mod_mpwm_chan
  import icosoc_mod_mpwm_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CNT_W-1:0] cnt,
  input  logic             load,
  input  logic             we_on,
  input  logic             we_off,
  input  logic             we_cfg,
  input  logic [CNT_W-1:0] wdat,
  input  logic [1:0]       wcfg,
  output logic [CNT_W-1:0] on_sh,
  output logic [CNT_W-1:0] off_sh,
  output logic [1:0]       cfg_sh,
  output logic             pin
);

  logic [CNT_W-1:0] on_a_q, off_a_q;
  logic [1:0]       cfg_a_q;
  logic             raw_q, raw_d, pin_d;

  // OFF is checked first so it wins when ON==OFF.
  always_comb begin
    raw_d = raw_q;
    if (!cfg_a_q[CFG_EN]) begin
      raw_d = 1'b0;
    end else if (cnt == off_a_q) begin
      raw_d = 1'b0;
    end else if (cnt == on_a_q) begin
      raw_d = 1'b1;
    end
    pin_d = cfg_a_q[CFG_EN] ? (raw_d ^ cfg_a_q[CFG_POL]) : cfg_a_q[CFG_POL];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      on_sh   <= '0;
      off_sh  <= '0;
      cfg_sh  <= '0;
      on_a_q  <= '0;
      off_a_q <= '0;
      cfg_a_q <= '0;
      raw_q   <= 1'b0;
      pin     <= 1'b0;
    end else begin
      if (we_on)  on_sh  <= wdat;
      if (we_off) off_sh <= wdat;
      if (we_cfg) cfg_sh <= wcfg;
      if (load) begin
        on_a_q  <= on_sh;
        off_a_q <= off_sh;
        cfg_a_q <= cfg_sh;
      end
      raw_q <= raw_d;
      pin   <= pin_d;
    end
  end

endmodule

// File: rtl/icosoc_mod_mpwm.sv
// Multi-channel PWM on the icosoc ctrl bus: bus decode, prescaler, shared period counter,
// shadow-register commit and status.
module icosoc_mod_mpwm
  import icosoc_mod_mpwm_pkg::*;
#(
  parameter int unsigned NCH   = 4,
  parameter int unsigned CNT_W = 16,
  parameter int unsigned PRE_W = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           ctrl_wr,
  input  logic           ctrl_rd,
  input  logic [15:0]    ctrl_addr,
  input  logic [31:0]    ctrl_wdat,
  output logic [31:0]    ctrl_rdat,
  output logic           ctrl_done,
  output logic [NCH-1:0] pins
);

  logic             done_q, run_q, pending_q, pending_d, wrap_q, wrap_d;
  logic [31:0]      rdat_q, rd_val;
  logic [CNT_W-1:0] period_sh_q, period_a_q, cnt_q, cnt_d;
  logic [PRE_W-1:0] pre_sh_q, pre_a_q, pre_q, pre_d;
  logic             req, wr_req, rd_req, tick, wrap, load, commit;
  logic             we_ctrl, we_period, we_pre, we_count, we_status, ch_hit, ch_wr;
  logic [15:0]      ch_rel;
  logic [3:0]       ch_idx, ch_sub;
  logic [CNT_W-1:0] on_sh [NCH];
  logic [CNT_W-1:0] off_sh [NCH];
  logic [1:0]       cfg_sh [NCH];
  logic             unused_wdat;

  assign unused_wdat = ^ctrl_wdat;

  // Requests are only sampled outside the ack cycle, so a held request acks once per pair.
  assign req    = (ctrl_wr | ctrl_rd) & ~done_q;
  assign wr_req = req & ctrl_wr;
  assign rd_req = req & ctrl_rd & ~ctrl_wr;

  assign ch_rel = ctrl_addr - CH_BASE;
  assign ch_idx = ch_rel[7:4];
  assign ch_sub = ch_rel[3:0];
  assign ch_hit = ({16'h0, ch_rel} < 32'(CH_STRIDE) * NCH);
  assign ch_wr  = wr_req & ch_hit;

  assign we_ctrl   = wr_req & (ctrl_addr == ADDR_CTRL);
  assign we_period = wr_req & (ctrl_addr == ADDR_PERIOD);
  assign we_pre    = wr_req & (ctrl_addr == ADDR_PRESCALE);
  assign we_count  = wr_req & (ctrl_addr == ADDR_COUNT);
  assign we_status = wr_req & (ctrl_addr == ADDR_STATUS);
  assign commit    = we_ctrl & ctrl_wdat[CTRL_COMMIT];

  assign tick = run_q & (pre_q == pre_a_q);
  assign wrap = tick & (cnt_q >= period_a_q);
  assign load = pending_q & (wrap | ~run_q);

  always_comb begin
    pre_d = pre_q;
    cnt_d = cnt_q;
    if (tick) begin
      pre_d = '0;
      cnt_d = (cnt_q >= period_a_q) ? '0 : cnt_q + 1'b1;
    end else if (run_q) begin
      pre_d = pre_q + 1'b1;
    end
    if (we_count) begin
      cnt_d = ctrl_wdat[CNT_W-1:0];
      pre_d = '0;
    end
    pending_d = commit ? 1'b1 : (load ? 1'b0 : pending_q);
    wrap_d    = wrap ? 1'b1 : ((we_status & ctrl_wdat[STAT_WRAP]) ? 1'b0 : wrap_q);
  end

  always_comb begin
    rd_val = '0;
    if (ctrl_addr == ADDR_CTRL) begin
      rd_val[CTRL_RUN] = run_q;
    end else if (ctrl_addr == ADDR_PERIOD) begin
      rd_val = 32'(period_sh_q);
    end else if (ctrl_addr == ADDR_PRESCALE) begin
      rd_val = 32'(pre_sh_q);
    end else if (ctrl_addr == ADDR_COUNT) begin
      rd_val = 32'(cnt_q);
    end else if (ctrl_addr == ADDR_STATUS) begin
      rd_val[STAT_PEND] = pending_q;
      rd_val[STAT_WRAP] = wrap_q;
    end else if (ch_hit) begin
      for (int c = 0; c < NCH; c++) begin
        if (ch_idx == 4'(c)) begin
          case (ch_sub)
            CH_ON:   rd_val = 32'(on_sh[c]);
            CH_OFF:  rd_val = 32'(off_sh[c]);
            CH_CFG:  rd_val = 32'(cfg_sh[c]);
            default: rd_val = '0;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      done_q      <= 1'b0;
      rdat_q      <= '0;
      run_q       <= 1'b0;
      pending_q   <= 1'b0;
      wrap_q      <= 1'b0;
      period_sh_q <= '0;
      period_a_q  <= '0;
      pre_sh_q    <= '0;
      pre_a_q     <= '0;
      pre_q       <= '0;
      cnt_q       <= '0;
    end else begin
      done_q    <= req;
      rdat_q    <= rd_req ? rd_val : '0;
      pending_q <= pending_d;
      wrap_q    <= wrap_d;
      pre_q     <= pre_d;
      cnt_q     <= cnt_d;
      if (we_ctrl)   run_q       <= ctrl_wdat[CTRL_RUN];
      if (we_period) period_sh_q <= ctrl_wdat[CNT_W-1:0];
      if (we_pre)    pre_sh_q    <= ctrl_wdat[PRE_W-1:0];
      if (load) begin
        period_a_q <= period_sh_q;
        pre_a_q    <= pre_sh_q;
      end
    end
  end

  assign ctrl_done = done_q;
  assign ctrl_rdat = rdat_q;

  for (genvar c = 0; c < NCH; c++) begin : g_chan
    logic sel;
    assign sel = ch_wr & (ch_idx == 4'(c));

    icosoc_mod_mpwm_chan #(
      .CNT_W(CNT_W)
    ) u_chan (
      .clk   (clk),
      .reset (reset),
      .cnt   (cnt_q),
      .load  (load),
      .we_on (sel & (ch_sub == CH_ON)),
      .we_off(sel & (ch_sub == CH_OFF)),
      .we_cfg(sel & (ch_sub == CH_CFG)),
      .wdat  (ctrl_wdat[CNT_W-1:0]),
      .wcfg  (ctrl_wdat[1:0]),
      .on_sh (on_sh[c]),
      .off_sh(off_sh[c]),
      .cfg_sh(cfg_sh[c]),
      .pin   (pins[c])
    );
  end

endmodule

// File: tb/tb_icosoc_mod_mpwm.sv
// Directed bench for icosoc_mod_mpwm: bus protocol, shadow commit, prescaler and pin waveforms.
module tb_icosoc_mod_mpwm;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ctrl_wr = 1'b0;
  logic        ctrl_rd = 1'b0;
  logic [15:0] ctrl_addr = '0;
  logic [31:0] ctrl_wdat = '0;
  logic [31:0] ctrl_rdat;
  logic        ctrl_done;
  logic [3:0]  pins;

  int n_total = 0;
  int n_bad = 0;

  icosoc_mod_mpwm #(
    .NCH  (4),
    .CNT_W(16),
    .PRE_W(8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .ctrl_wr  (ctrl_wr),
    .ctrl_rd  (ctrl_rd),
    .ctrl_addr(ctrl_addr),
    .ctrl_wdat(ctrl_wdat),
    .ctrl_rdat(ctrl_rdat),
    .ctrl_done(ctrl_done),
    .pins     (pins)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic bus_wr(input logic [15:0] addr, input logic [31:0] data);
    logic seen = 1'b0;
    @(negedge clk);
    ctrl_wr   = 1'b1;
    ctrl_addr = addr;
    ctrl_wdat = data;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (ctrl_done) begin
        seen = 1'b1;
        break;
      end
    end
    ctrl_wr = 1'b0;
    if (!seen) check("wr_ack_timeout", 32'(seen), 32'd1);
  endtask

  task automatic bus_rd(input logic [15:0] addr, output logic [31:0] data);
    logic seen = 1'b0;
    data = '0;
    @(negedge clk);
    ctrl_rd   = 1'b1;
    ctrl_addr = addr;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (ctrl_done) begin
        seen = 1'b1;
        data = ctrl_rdat;
        break;
      end
    end
    ctrl_rd = 1'b0;
    if (!seen) check("rd_ack_timeout", 32'(seen), 32'd1);
  endtask

  task automatic rd_check(input string tag, input logic [15:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    bus_rd(addr, d);
    check(tag, d, exp);
  endtask

  task automatic sync_rise(input int ch);
    logic prev, found;
    found = 1'b0;
    @(negedge clk);
    prev = pins[ch];
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!prev && pins[ch]) begin
        found = 1'b1;
        break;
      end
      prev = pins[ch];
    end
    if (!found) check("rise_timeout", 32'(found), 32'd1);
  endtask

  task automatic measure(input int ch, output int hi, output int lo);
    sync_rise(ch);
    hi = 1;
    lo = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (pins[ch]) hi++;
      else break;
    end
    lo = 1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!pins[ch]) lo++;
      else break;
    end
  endtask

  task automatic wait_commit();
    logic [31:0] d;
    logic cleared = 1'b0;
    for (int i = 0; i < 100; i++) begin
      bus_rd(16'h0010, d);
      if (!d[0]) begin
        cleared = 1'b1;
        break;
      end
    end
    check("commit_clears", 32'(cleared), 32'd1);
  endtask

  task automatic count_high(input int ch, input int n, output int highs);
    highs = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (pins[ch]) highs++;
    end
  endtask

  initial begin
    int hi, lo, highs, dones;
    logic [31:0] d;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst_pins", 32'(pins), 32'h0);
    check("rst_done", 32'(ctrl_done), 32'h0);
    check("rst_rdat", ctrl_rdat, 32'h0);
    rd_check("rst_count", 16'h000C, 32'h0);
    rd_check("rst_status", 16'h0010, 32'h0);

    // 1: period 10, ch0 high for cnt 0..2
    bus_wr(16'h0004, 32'd9);
    bus_wr(16'h0008, 32'd0);
    bus_wr(16'h0100, 32'd0);
    bus_wr(16'h0104, 32'd3);
    bus_wr(16'h0108, 32'd1);
    bus_wr(16'h0000, 32'h2);
    bus_wr(16'h0000, 32'h1);
    measure(0, hi, lo);
    check("t1_high", 32'(hi), 32'd3);
    check("t1_low", 32'(lo), 32'd7);

    // 2: shadow write alone changes nothing; commit applies at the next wrap
    bus_wr(16'h0104, 32'd6);
    measure(0, hi, lo);
    check("t2_nocommit_high", 32'(hi), 32'd3);
    check("t2_nocommit_low", 32'(lo), 32'd7);
    sync_rise(0);
    bus_wr(16'h0000, 32'h3);
    rd_check("t2_pending", 16'h0010, 32'h3);
    measure(0, hi, lo);
    check("t2_commit_high", 32'(hi), 32'd6);
    check("t2_commit_low", 32'(lo), 32'd4);
    rd_check("t2_pending_clr", 16'h0010, 32'h2);

    // 3: prescale 3, period 4 -> cnt steps every 4 clks, wrap every 20
    bus_wr(16'h0008, 32'd3);
    bus_wr(16'h0004, 32'd4);
    bus_wr(16'h0104, 32'd1);
    bus_wr(16'h0000, 32'h3);
    wait_commit();
    measure(0, hi, lo);
    check("t3_high", 32'(hi), 32'd4);
    check("t3_low", 32'(lo), 32'd16);
    rd_check("t3_wrap_set", 16'h0010, 32'h2);
    sync_rise(0);
    bus_wr(16'h0010, 32'h2);
    rd_check("t3_wrap_clr", 16'h0010, 32'h0);

    // 4: ON==OFF stays low; en=0 pol=1 is constant 1; ON beyond PERIOD never rises
    bus_wr(16'h0100, 32'd2);
    bus_wr(16'h0104, 32'd2);
    bus_wr(16'h0000, 32'h3);
    wait_commit();
    count_high(0, 40, highs);
    check("t4_on_eq_off", 32'(highs), 32'd0);
    bus_wr(16'h0108, 32'h2);
    bus_wr(16'h0000, 32'h3);
    wait_commit();
    count_high(0, 40, highs);
    check("t4_pol_dis", 32'(highs), 32'd40);
    bus_wr(16'h0100, 32'd5);
    bus_wr(16'h0108, 32'h1);
    bus_wr(16'h0000, 32'h3);
    wait_commit();
    count_high(0, 40, highs);
    check("t4_on_gt_per", 32'(highs), 32'd0);

    // 5: bus behaviour
    @(negedge clk);
    ctrl_wr   = 1'b1;
    ctrl_addr = 16'h0080;
    ctrl_wdat = 32'hDEAD;
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (ctrl_done) dones++;
    end
    ctrl_wr = 1'b0;
    @(posedge clk);
    #1;
    if (ctrl_done) dones++;
    check("t5_held_acks", 32'(dones), 32'd3);
    rd_check("t5_unmapped", 16'h0080, 32'h0);
    bus_wr(16'h0140, 32'hFFFF);
    rd_check("t5_ch_oob", 16'h0140, 32'h0);
    rd_check("t5_on_rb", 16'h0100, 32'd5);
    rd_check("t5_off_rb", 16'h0104, 32'd2);
    rd_check("t5_cfg_rb", 16'h0108, 32'd1);
    rd_check("t5_ctrl_rb", 16'h0000, 32'h1);
    rd_check("t5_pre_rb", 16'h0008, 32'd3);
    bus_wr(16'h0004, 32'h12345);
    rd_check("t5_trunc", 16'h0004, 32'h2345);
    bus_wr(16'h0004, 32'd4);
    bus_wr(16'h0000, 32'h0);
    bus_wr(16'h000C, 32'd3);
    rd_check("t5_count_ld", 16'h000C, 32'd3);
    repeat (10) @(negedge clk);
    rd_check("t5_count_frz", 16'h000C, 32'd3);

    // 6: reset mid-period while running
    bus_wr(16'h0100, 32'd0);
    bus_wr(16'h0104, 32'd2);
    bus_wr(16'h0000, 32'h3);
    wait_commit();
    sync_rise(0);
    check("t6_pin_hi", 32'(pins[0]), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t6_pins", 32'(pins), 32'h0);
    rd_check("t6_count", 16'h000C, 32'h0);
    rd_check("t6_status", 16'h0010, 32'h0);
    rd_check("t6_on_sh", 16'h0100, 32'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
